// File: rtl/pair_detect_scheduler_pkg.sv
// Shared types and helpers for the pair-detect scheduler and its serial detector.
package pair_detect_scheduler_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } sched_state_t;

    // Detector states: A = no history, B = last bit 0, C = last bit 1.
    typedef enum logic [1:0] {
        DET_A = 2'b00,
        DET_B = 2'b01,
        DET_C = 2'b10
    } det_state_t;

    // Requester to serve: a lone request wins outright; a tie goes to ptr.
    function automatic logic pick_requester(input logic [1:0] req, input logic ptr);
        return (req == 2'b11) ? ptr : req[1];
    endfunction

endpackage

// File: rtl/pair_detect_scheduler_if.sv
// Request/grant/result bundle between the two word sources and the scheduler.
interface pair_detect_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [CNT_W-1:0] count;

    // Requester side: drives requests and words, observes grants and results.
    modport master (
        output req, data0, data1,
        input  gnt, busy, done, done_id, count
    );

    // Scheduler side.
    modport slave (
        input  req, data0, data1,
        output gnt, busy, done, done_id, count
    );
endinterface

// File: rtl/pair_detect_scheduler_core.sv
// Mealy detector flagging two equal consecutive bits (00 or 11) on a serial stream.
module pair_detect_core
    import pair_detect_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,   // asynchronous, active-low
    input  logic clr,     // synchronous return to state A
    input  logic en,      // advance on this edge
    input  logic w,
    output logic z
);

    det_state_t state_q;
    det_state_t state_d;

    // Hit output and next state from the current state and incoming bit.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_d = DET_A;
        z       = 1'b0;
        case (state_q)
            DET_A: begin
                state_d = w ? DET_C : DET_B;
            end
            DET_B: begin
                state_d = w ? DET_C : DET_B;
                z       = ~w;
            end
            DET_C: begin
                state_d = w ? DET_C : DET_B;
                z       = w;
            end
            default: begin
                state_d = DET_A;
                z       = 1'b0;
            end
        endcase
    end

    // State register: clear has priority over advance.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!reset) begin
            state_q <= DET_A;
        end else if (clr) begin
            state_q <= DET_A;
        end else if (en) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pair_detect_scheduler.sv
// Round-robin scheduler: grants one of two requesters, serializes its word MSB-first
// through the pair detector and returns the hit count tagged with the requester id.
module pair_detect_scheduler
    import pair_detect_scheduler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,   // asynchronous, active-low
    pair_detect_scheduler_if.slave  bus
);

    localparam int              BC_W     = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    sched_state_t     state_q;
    logic             ptr_q;       // tie winner for the next simultaneous request
    logic             sel_q;       // requester being served
    logic [WIDTH-1:0] sr_q;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       gnt_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;

    logic             sel_d;
    logic             det_clr;
    logic             det_en;
    logic             det_w;
    logic             det_z;

    assign sel_d   = pick_requester(bus.req, ptr_q);
    assign det_clr = (state_q == ST_LOAD);
    assign det_en  = (state_q == ST_SHIFT);
    assign det_w   = sr_q[WIDTH-1];

    pair_detect_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .en    (det_en),
        .w     (det_w),
        .z     (det_z)
    );

    // Control FSM with registered outputs; grant and done are one-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            sel_q     <= 1'b0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            count_q   <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req != 2'b00) begin
                        // Outputs seen during LOAD: grant, id, cleared count.
                        state_q   <= ST_LOAD;
                        gnt_q     <= sel_d ? 2'b10 : 2'b01;
                        sel_q     <= sel_d;
                        ptr_q     <= ~sel_d;
                        done_id_q <= sel_d;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Word is captured at the end of LOAD; later data changes are ignored.
                    sr_q      <= sel_q ? bus.data1 : bus.data0;
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr_q      <= {sr_q[WIDTH-2:0], 1'b0};
                    count_q   <= count_q + CNT_W'(det_z);
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.count   = count_q;

endmodule

// File: tb/tb_pair_detect_scheduler.sv
// Directed bench for pair_detect_scheduler: latency, hit counts, arbitration and reset.
module tb_pair_detect_scheduler;

    logic clk = 1'b0;
    logic reset;

    pair_detect_scheduler_if #(.WIDTH(8), .CNT_W(4)) bus_if ();

    pair_detect_scheduler #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int fail_cnt    = 0;
    int done_seen   = 0;
    int overlap_cnt = 0;

    // Background monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (bus_if.done === 1'b1) done_seen++;
        if (bus_if.gnt === 2'b11) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"},     32'(bus_if.gnt),     32'h0);
        check({tag, "_busy"},    32'(bus_if.busy),    32'h0);
        check({tag, "_done"},    32'(bus_if.done),    32'h0);
        check({tag, "_done_id"}, 32'(bus_if.done_id), 32'h0);
        check({tag, "_count"},   32'(bus_if.count),   32'h0);
    endtask

    // Entered on a falling edge with the DUT idle; returns on the falling edge
    // after DONE (DUT back in IDLE).
    task automatic do_word(input string tag, input logic [1:0] r_in, input logic [1:0] r_after,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [1:0] exp_gnt, input logic [3:0] exp_cnt,
                           input logic exp_id, input bit scramble);
        int edges;
        bus_if.req   = r_in;
        bus_if.data0 = d0;
        bus_if.data1 = d1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_gnt"},  32'(bus_if.gnt),  32'(exp_gnt));
        check({tag, "_busy"}, 32'(bus_if.busy), 32'h1);
        bus_if.req = r_after;
        edges = 1;
        while (bus_if.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (scramble && edges >= 2) begin
                bus_if.data0 = 8'($urandom);
                bus_if.data1 = 8'($urandom);
            end
        end
        check({tag, "_latency"}, 32'(edges), 32'd10);
        check({tag, "_count"},   32'(bus_if.count),   32'(exp_cnt));
        check({tag, "_done_id"}, 32'(bus_if.done_id), 32'(exp_id));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus_if.done),  32'h0);
        check({tag, "_idle"},       32'(bus_if.busy),  32'h0);
        check({tag, "_held_count"}, 32'(bus_if.count), 32'(exp_cnt));
    endtask

    initial begin
        int done_before;
        reset        = 1'b0;
        bus_if.req   = 2'b00;
        bus_if.data0 = 8'h00;
        bus_if.data1 = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        // Single requesters, known hit counts.
        do_word("cc_r0", 2'b01, 2'b00, 8'hCC, 8'h00, 2'b01, 4'd4, 1'b0, 1'b0);
        do_word("aa_r1", 2'b10, 2'b00, 8'hFF, 8'hAA, 2'b10, 4'd0, 1'b1, 1'b0);
        do_word("ff_r1", 2'b10, 2'b00, 8'h00, 8'hFF, 2'b10, 4'd7, 1'b1, 1'b0);
        do_word("00_r1", 2'b10, 2'b00, 8'hFF, 8'h00, 2'b10, 4'd7, 1'b1, 1'b0);

        // Tie straight out of reset: requester 0 first, loser served next.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_word("tie_e1", 2'b11, 2'b10, 8'hE1, 8'h0F, 2'b01, 4'd5, 1'b0, 1'b0);
        do_word("tie_0f", 2'b10, 2'b00, 8'hE1, 8'h0F, 2'b10, 4'd6, 1'b1, 1'b0);

        // Both held for four words: grants alternate starting at requester 0.
        done_before = done_seen;
        do_word("rr0", 2'b11, 2'b11, 8'hCC, 8'hAA, 2'b01, 4'd4, 1'b0, 1'b0);
        do_word("rr1", 2'b11, 2'b11, 8'hCC, 8'hAA, 2'b10, 4'd0, 1'b1, 1'b0);
        do_word("rr2", 2'b11, 2'b11, 8'hCC, 8'hAA, 2'b01, 4'd4, 1'b0, 1'b0);
        do_word("rr3", 2'b11, 2'b00, 8'hCC, 8'hAA, 2'b10, 4'd0, 1'b1, 1'b0);
        check("rr_done_pulses", 32'(done_seen - done_before), 32'd4);
        check("gnt_overlap",    32'(overlap_cnt),             32'd0);

        // Reset during SHIFT bit 3 of a requester-1 word.
        bus_if.req   = 2'b10;
        bus_if.data1 = 8'hCC;
        @(posedge clk);
        @(negedge clk);
        check("mid_gnt", 32'(bus_if.gnt), 32'h2);
        bus_if.req = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy",  32'(bus_if.busy),    32'h1);
        check("mid_count", 32'(bus_if.count),   32'd1);
        check("mid_id",    32'(bus_if.done_id), 32'h1);
        done_before = done_seen;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_rst", 32'(done_seen - done_before), 32'd0);
        do_word("cc_after_rst", 2'b01, 2'b00, 8'hCC, 8'h00, 2'b01, 4'd4, 1'b0, 1'b0);

        // Data scrambled during SHIFT must not affect the captured word (F0 -> 6 hits).
        do_word("toggle", 2'b01, 2'b00, 8'hF0, 8'h3C, 2'b01, 4'd6, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
